// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// op encodings, FSM state enum and sign helpers.
package pipeline_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_FIX  = 2'b11
    } muldiv_state_e;

    // 0x80000000 maps to magnitude 2^31, still representable as unsigned.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x,
                                                   input logic is_signed);
        return (is_signed && x[MD_WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [MD_WIDTH-1:0] md_neg(input logic [MD_WIDTH-1:0] x,
                                                   input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*MD_WIDTH-1:0] md_neg_dw(input logic [2*MD_WIDTH-1:0] x,
                                                        input logic en);
        return en ? -x : x;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one result bit per cycle.
// Valid/ready: start is taken only when the FSM is IDLE and flush is low; busy reports non-IDLE.
module ex_muldiv_unit
    import pipeline_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output muldiv_state_e    dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_e      state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               op_mul;
    logic               sign_q;
    logic               sign_r;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] fix_val;

    assign dbg_state = state;
    assign is_signed = ~op[0];
    assign a_mag     = md_abs(opa, is_signed);
    assign b_mag     = md_abs(opb, is_signed);

    // acc upper half: partial product / partial remainder; lower half: multiplier / quotient.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand};
        div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        fix_val  = op_mul ? md_neg_dw(acc, sign_q)
                          : {md_neg(acc[2*WIDTH-1:WIDTH], sign_r), md_neg(acc[WIDTH-1:0], sign_q)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            op_mul <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= MD_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    MD_IDLE: begin
                        if (start) begin
                            cnt    <= '0;
                            busy   <= 1'b1;
                            op_mul <= ~op[1];
                            if (op[1] && opb == '0) begin
                                // Divide by zero: raw result, no sign processing.
                                acc    <= {opa, {WIDTH{1'b1}}};
                                sign_q <= 1'b0;
                                sign_r <= 1'b0;
                                state  <= MD_FIX;
                            end else begin
                                sign_q <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                                sign_r <= is_signed & opa[WIDTH-1];
                                if (op[1]) begin
                                    acc   <= {{WIDTH{1'b0}}, a_mag};
                                    mcand <= b_mag;
                                    state <= MD_DIV;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, b_mag};
                                    mcand <= a_mag;
                                    state <= MD_MUL;
                                end
                            end
                        end else begin
                            if (hi_we) hi <= wdata;
                            if (lo_we) lo <= wdata;
                        end
                    end
                    MD_MUL, MD_DIV: begin
                        acc <= (state == MD_MUL) ? mul_next : div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= MD_FIX;
                    end
                    MD_FIX: begin
                        {hi, lo} <= fix_val;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= MD_IDLE;
                    end
                    default: state <= MD_IDLE;
                endcase
            end
        end
    end

endmodule
